// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared constants and types for the up/down counter slice.
//   - DIR_UP / DIR_DOWN   : values of the up_down input.
//   - MODE_WRAP / MODE_SAT: values of the SATURATE parameter.
//   - step_e              : classification of what a count step does to Q.
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // What the counting datapath does on a qualifying edge when neither clear
  // nor load is active.
  typedef enum logic [2:0] {
    STEP_NONE      = 3'd0,  // no step this cycle
    STEP_INC       = 3'd1,  // Q + 1
    STEP_DEC       = 3'd2,  // Q - 1
    STEP_WRAP_UP   = 3'd3,  // MAX_COUNT -> 0, pulse wrap
    STEP_WRAP_DOWN = 3'd4,  // 0 -> MAX_COUNT, pulse wrap
    STEP_HOLD      = 3'd5   // saturated at a limit, Q unchanged
  } step_e;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler
//   Divides enabled cycles by PRESCALE. tick is high while the internal
//   count equals PRESCALE-1; on the next enabled edge the count returns to 0.
//   With PRESCALE=1 the count never leaves 0, so tick is constantly 1.
//
// Ports
//   clk     in  : rising-edge clock
//   n_reset in  : asynchronous active-low reset, zeroes the count
//   clr     in  : synchronous zero of the count (has priority over enable)
//   enable  in  : advance the count on this edge
//   tick    out : combinational, count == PRESCALE-1
// ---------------------------------------------------------------------------
module counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  input  logic enable,
  output logic tick
);

  // A one-bit register is kept even for PRESCALE=1; it simply stays at 0.
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : counter_prescaler

// File: rtl/counter_updown_param.sv
// ---------------------------------------------------------------------------
// counter_updown_param
//   Parameterised up/down counter with terminal value MAX_COUNT, optional
//   saturation, enable prescaler and carry output for cascading.
//   Priority on each edge: clear > load > count step.
//
// Parameters
//   WIDTH     : count width (2..64)
//   MAX_COUNT : terminal value (1..2**WIDTH-1)
//   SATURATE  : MODE_WRAP (0) wraps at the limits, MODE_SAT (1) holds
//   PRESCALE  : enabled cycles per count step (1..65535)
//
// Ports
//   clk        in  : rising-edge clock
//   n_reset    in  : asynchronous active-low reset
//   clear      in  : synchronous clear of Q (and prescaler) to 0
//   load       in  : synchronous load of min(load_value, MAX_COUNT)
//   load_value in  : value to load
//   enable     in  : count enable
//   up_down    in  : direction, DIR_UP (1) or DIR_DOWN (0)
//   Q          out : registered count
//   at_limit   out : Q sits at the limit for the current direction
//   carry_out  out : enable & step_tick & at_limit, feeds the next stage
//   wrap       out : registered pulse, high the cycle after a wrap step
// ---------------------------------------------------------------------------
module counter_updown_param
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  MAX_COUNT = {WIDTH{1'b1}},
  parameter int unsigned       SATURATE  = MODE_WRAP,
  parameter int unsigned       PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] Q,
  output logic             at_limit,
  output logic             carry_out,
  output logic             wrap
);

  localparam bit SAT_MODE = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             step_tick;
  logic             pre_clr;
  logic             pre_en;
  logic             count_step;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   max_ext;
  logic             up_over;
  logic             down_under;
  logic [WIDTH-1:0] load_clamped;
  step_e            step_kind;

  // Clear and load both restart the prescale period; the prescaler only
  // advances on cycles where a count step could actually happen.
  assign pre_clr = clear | load;
  assign pre_en  = enable & ~pre_clr;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (pre_clr),
    .enable  (pre_en),
    .tick    (step_tick)
  );

  assign count_step = pre_en & step_tick;

  // One extra bit keeps the limit tests exact when MAX_COUNT = 2**WIDTH-1:
  // the increment lands in bit WIDTH instead of silently wrapping, and the
  // decrement of 0 shows up as a borrow in bit WIDTH.
  assign inc_ext    = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_ext    = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
  assign max_ext    = {1'b0, MAX_COUNT};
  assign up_over    = (inc_ext > max_ext);
  assign down_under = dec_ext[WIDTH];

  assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

  // Classify the step; direction is taken from this cycle's up_down.
  always_comb begin
    step_kind = STEP_NONE;
    if (count_step) begin
      if (up_down == DIR_UP) begin
        if (!up_over) begin
          step_kind = STEP_INC;
        end else if (SAT_MODE) begin
          step_kind = STEP_HOLD;
        end else begin
          step_kind = STEP_WRAP_UP;
        end
      end else begin
        if (!down_under) begin
          step_kind = STEP_DEC;
        end else if (SAT_MODE) begin
          step_kind = STEP_HOLD;
        end else begin
          step_kind = STEP_WRAP_DOWN;
        end
      end
    end
  end

  // Next-state for Q and wrap. wrap_d defaults low so the pulse lasts
  // exactly one cycle and never follows a clear, load or hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_clamped;
    end else begin
      case (step_kind)
        STEP_INC:       q_d = inc_ext[WIDTH-1:0];
        STEP_DEC:       q_d = dec_ext[WIDTH-1:0];
        STEP_WRAP_UP: begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
        STEP_WRAP_DOWN: begin
          q_d    = MAX_COUNT;
          wrap_d = 1'b1;
        end
        default:        q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign wrap = wrap_q;

  assign at_limit  = (up_down == DIR_UP) ? (q_q == MAX_COUNT) : (q_q == '0);
  assign carry_out = enable & step_tick & at_limit;

endmodule : counter_updown_param

// File: tb/tb_counter_updown_param.sv
module tb_counter_updown_param;

  logic clk;
  logic n_reset;

  // shared controls for the four 8-bit instances
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       enable;
  logic       up_down;

  // a: wrap, MAX 9, P1   s: saturate, MAX 9, P1
  // p: wrap, MAX 9, P3   w: wrap, default MAX 255, P1
  logic [7:0] a_q, s_q, p_q, w_q;
  logic a_lim, a_cy, a_wr;
  logic s_lim, s_cy, s_wr;
  logic p_lim, p_cy, p_wr;
  logic w_lim, w_cy, w_wr;

  // cascade pair
  logic        c_clear, c_load, c_enable, c_up;
  logic [15:0] lo_val, hi_val;
  logic [15:0] lo_q, hi_q;
  logic lo_lim, lo_cy, lo_wr;
  logic hi_lim, hi_cy, hi_wr;

  int n_cmp;
  int n_bad;

  counter_updown_param #(.WIDTH(8), .MAX_COUNT(8'd9), .SATURATE(0), .PRESCALE(1)) dut_a (
    .clk(clk), .n_reset(n_reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .Q(a_q), .at_limit(a_lim), .carry_out(a_cy), .wrap(a_wr));

  counter_updown_param #(.WIDTH(8), .MAX_COUNT(8'd9), .SATURATE(1), .PRESCALE(1)) dut_s (
    .clk(clk), .n_reset(n_reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .Q(s_q), .at_limit(s_lim), .carry_out(s_cy), .wrap(s_wr));

  counter_updown_param #(.WIDTH(8), .MAX_COUNT(8'd9), .SATURATE(0), .PRESCALE(3)) dut_p (
    .clk(clk), .n_reset(n_reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .Q(p_q), .at_limit(p_lim), .carry_out(p_cy), .wrap(p_wr));

  counter_updown_param #(.WIDTH(8)) dut_w (
    .clk(clk), .n_reset(n_reset), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .Q(w_q), .at_limit(w_lim), .carry_out(w_cy), .wrap(w_wr));

  counter_updown_param #(.WIDTH(16)) dut_lo (
    .clk(clk), .n_reset(n_reset), .clear(c_clear), .load(c_load), .load_value(lo_val),
    .enable(c_enable), .up_down(c_up), .Q(lo_q), .at_limit(lo_lim), .carry_out(lo_cy), .wrap(lo_wr));

  counter_updown_param #(.WIDTH(16)) dut_hi (
    .clk(clk), .n_reset(n_reset), .clear(c_clear), .load(c_load), .load_value(hi_val),
    .enable(lo_cy), .up_down(c_up), .Q(hi_q), .at_limit(hi_lim), .carry_out(hi_cy), .wrap(hi_wr));

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0;
    load = 1'b0;
    enable = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_reset = 1'b0;
    idle_inputs();
    load_value = 8'd0;
    up_down = 1'b1;
    c_clear = 1'b0; c_load = 1'b0; c_enable = 1'b0; c_up = 1'b1;
    lo_val = 16'd0; hi_val = 16'd0;
    #3;
    n_cmp++; if (a_q !== 8'd0) begin n_bad++; $display("FAIL reset_a_q got=%0d exp=0", a_q); end
    n_cmp++; if (a_wr !== 1'b0) begin n_bad++; $display("FAIL reset_a_wrap got=%b exp=0", a_wr); end
    n_cmp++; if (p_q !== 8'd0) begin n_bad++; $display("FAIL reset_p_q got=%0d exp=0", p_q); end
    n_cmp++; if (a_lim !== 1'b0) begin n_bad++; $display("FAIL reset_lim_up got=%b exp=0", a_lim); end
    up_down = 1'b0;
    #1;
    n_cmp++; if (a_lim !== 1'b1) begin n_bad++; $display("FAIL reset_lim_down got=%b exp=1", a_lim); end
    n_cmp++; if (a_cy !== 1'b0) begin n_bad++; $display("FAIL reset_carry_noen got=%b exp=0", a_cy); end
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    up_down = 1'b1;
  endtask

  task automatic test_count_up();
    int exp_v;
    int prev;
    do_clear();
    up_down = 1'b1;
    enable = 1'b1;
    exp_v = 0;
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (a_cy !== (exp_v == 9)) begin
        n_bad++; $display("FAIL up_carry i=%0d got=%b exp=%b", i, a_cy, (exp_v == 9));
      end
      prev = exp_v;
      step();
      exp_v = (exp_v == 9) ? 0 : exp_v + 1;
      n_cmp++;
      if (a_q !== 8'(exp_v)) begin n_bad++; $display("FAIL up_q i=%0d got=%0d exp=%0d", i, a_q, exp_v); end
      n_cmp++;
      if (a_wr !== (prev == 9)) begin
        n_bad++; $display("FAIL up_wrap i=%0d got=%b exp=%b", i, a_wr, (prev == 9));
      end
    end
    enable = 1'b0;
    step();
    n_cmp++; if (a_q !== 8'd1) begin n_bad++; $display("FAIL up_hold got=%0d exp=1", a_q); end
    n_cmp++; if (a_wr !== 1'b0) begin n_bad++; $display("FAIL up_hold_wrap got=%b exp=0", a_wr); end
  endtask

  task automatic test_count_down();
    do_clear();
    up_down = 1'b0;
    enable = 1'b1;
    #1;
    n_cmp++; if (a_lim !== 1'b1) begin n_bad++; $display("FAIL down_lim got=%b exp=1", a_lim); end
    n_cmp++; if (a_cy !== 1'b1) begin n_bad++; $display("FAIL down_carry got=%b exp=1", a_cy); end
    step();
    n_cmp++; if (a_q !== 8'd9) begin n_bad++; $display("FAIL down_wrap_q got=%0d exp=9", a_q); end
    n_cmp++; if (a_wr !== 1'b1) begin n_bad++; $display("FAIL down_wrap_pulse got=%b exp=1", a_wr); end
    n_cmp++; if (s_q !== 8'd0) begin n_bad++; $display("FAIL down_sat_q got=%0d exp=0", s_q); end
    n_cmp++; if (s_wr !== 1'b0) begin n_bad++; $display("FAIL down_sat_wrap got=%b exp=0", s_wr); end
    step();
    n_cmp++; if (a_q !== 8'd8) begin n_bad++; $display("FAIL down_q8 got=%0d exp=8", a_q); end
    n_cmp++; if (a_wr !== 1'b0) begin n_bad++; $display("FAIL down_wrap_drop got=%b exp=0", a_wr); end
    // saturating counter held at MAX while counting up
    enable = 1'b0;
    load = 1'b1;
    load_value = 8'd9;
    step();
    load = 1'b0;
    up_down = 1'b1;
    enable = 1'b1;
    step();
    n_cmp++; if (s_q !== 8'd9) begin n_bad++; $display("FAIL sat_up_q got=%0d exp=9", s_q); end
    n_cmp++; if (s_wr !== 1'b0) begin n_bad++; $display("FAIL sat_up_wrap got=%b exp=0", s_wr); end
    n_cmp++; if (a_q !== 8'd0) begin n_bad++; $display("FAIL wrap_up_q got=%0d exp=0", a_q); end
    n_cmp++; if (a_wr !== 1'b1) begin n_bad++; $display("FAIL wrap_up_pulse got=%b exp=1", a_wr); end
    enable = 1'b0;
    step();
    n_cmp++; if (a_wr !== 1'b0) begin n_bad++; $display("FAIL wrap_one_cycle got=%b exp=0", a_wr); end
  endtask

  task automatic test_load_priority();
    clear = 1'b1;
    load = 1'b1;
    load_value = 8'd5;
    enable = 1'b1;
    step();
    n_cmp++; if (a_q !== 8'd0) begin n_bad++; $display("FAIL clr_over_load got=%0d exp=0", a_q); end
    n_cmp++; if (a_wr !== 1'b0) begin n_bad++; $display("FAIL clr_wrap got=%b exp=0", a_wr); end
    clear = 1'b0;
    load_value = 8'd200;
    step();
    n_cmp++; if (a_q !== 8'd9) begin n_bad++; $display("FAIL load_clamp got=%0d exp=9", a_q); end
    n_cmp++; if (w_q !== 8'd200) begin n_bad++; $display("FAIL load_noclamp got=%0d exp=200", w_q); end
    n_cmp++; if (a_wr !== 1'b0) begin n_bad++; $display("FAIL load_wrap got=%b exp=0", a_wr); end
    load = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_full_range();
    load = 1'b1;
    load_value = 8'd255;
    step();
    n_cmp++; if (w_q !== 8'd255) begin n_bad++; $display("FAIL wide_load got=%0d exp=255", w_q); end
    load = 1'b0;
    enable = 1'b1;
    up_down = 1'b1;
    #1;
    n_cmp++; if (w_cy !== 1'b1) begin n_bad++; $display("FAIL wide_carry got=%b exp=1", w_cy); end
    step();
    n_cmp++; if (w_q !== 8'd0) begin n_bad++; $display("FAIL wide_wrap_up got=%0d exp=0", w_q); end
    n_cmp++; if (w_wr !== 1'b1) begin n_bad++; $display("FAIL wide_wrap_up_pulse got=%b exp=1", w_wr); end
    up_down = 1'b0;
    #1;
    n_cmp++; if (w_lim !== 1'b1) begin n_bad++; $display("FAIL wide_lim_dir got=%b exp=1", w_lim); end
    step();
    n_cmp++; if (w_q !== 8'd255) begin n_bad++; $display("FAIL wide_wrap_down got=%0d exp=255", w_q); end
    n_cmp++; if (w_wr !== 1'b1) begin n_bad++; $display("FAIL wide_wrap_down_pulse got=%b exp=1", w_wr); end
    enable = 1'b0;
    step();
    n_cmp++; if (w_wr !== 1'b0) begin n_bad++; $display("FAIL wide_wrap_drop got=%b exp=0", w_wr); end
  endtask

  task automatic test_prescale();
    logic en_tab [11];
    int   q_tab [11];
    en_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    q_tab  = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
    do_clear();
    up_down = 1'b1;
    for (int i = 0; i < 11; i++) begin
      enable = en_tab[i];
      step();
      n_cmp++;
      if (p_q !== 8'(q_tab[i])) begin
        n_bad++; $display("FAIL prescale_q edge=%0d got=%0d exp=%0d", i + 1, p_q, q_tab[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic reset_pulse();
    #2;
    n_reset = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    // reset while a wrap pulse is showing
    load = 1'b1;
    load_value = 8'd9;
    step();
    load = 1'b0;
    enable = 1'b1;
    up_down = 1'b1;
    step();
    n_cmp++; if (a_wr !== 1'b1) begin n_bad++; $display("FAIL pre_reset_wrap got=%b exp=1", a_wr); end
    reset_pulse();
    n_cmp++; if (a_wr !== 1'b0) begin n_bad++; $display("FAIL async_wrap got=%b exp=0", a_wr); end
    n_cmp++; if (p_q !== 8'd0) begin n_bad++; $display("FAIL async_p_q9 got=%0d exp=0", p_q); end
    #1;
    n_reset = 1'b1;
    // reset with Q=7 and the prescaler two counts in
    load = 1'b1;
    load_value = 8'd7;
    step();
    load = 1'b0;
    step();
    step();
    n_cmp++; if (p_q !== 8'd7) begin n_bad++; $display("FAIL mid_q7 got=%0d exp=7", p_q); end
    reset_pulse();
    n_cmp++; if (p_q !== 8'd0) begin n_bad++; $display("FAIL async_q got=%0d exp=0", p_q); end
    #1;
    n_reset = 1'b1;
    step();
    n_cmp++; if (p_q !== 8'd0) begin n_bad++; $display("FAIL post_rst_e1 got=%0d exp=0", p_q); end
    n_cmp++; if (a_wr !== 1'b0) begin n_bad++; $display("FAIL post_rst_wrap got=%b exp=0", a_wr); end
    step();
    n_cmp++; if (p_q !== 8'd0) begin n_bad++; $display("FAIL post_rst_e2 got=%0d exp=0", p_q); end
    step();
    n_cmp++; if (p_q !== 8'd1) begin n_bad++; $display("FAIL post_rst_e3 got=%0d exp=1", p_q); end
    enable = 1'b0;
  endtask

  task automatic test_cascade();
    c_load = 1'b1;
    lo_val = 16'hFFFF;
    hi_val = 16'h0000;
    step();
    c_load = 1'b0;
    c_enable = 1'b1;
    c_up = 1'b1;
    #1;
    n_cmp++; if (lo_cy !== 1'b1) begin n_bad++; $display("FAIL casc_carry got=%b exp=1", lo_cy); end
    step();
    n_cmp++;
    if ({hi_q, lo_q} !== 32'h0001_0000) begin
      n_bad++; $display("FAIL casc_step1 got=%h exp=00010000", {hi_q, lo_q});
    end
    n_cmp++; if (hi_wr !== 1'b0) begin n_bad++; $display("FAIL casc_hi_wrap got=%b exp=0", hi_wr); end
    step();
    n_cmp++;
    if ({hi_q, lo_q} !== 32'h0001_0001) begin
      n_bad++; $display("FAIL casc_step2 got=%h exp=00010001", {hi_q, lo_q});
    end
    n_cmp++; if (lo_cy !== 1'b0) begin n_bad++; $display("FAIL casc_carry_low got=%b exp=0", lo_cy); end
    c_enable = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_priority();
    test_full_range();
    test_prescale();
    test_reset_mid();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_counter_updown_param

// File: doc/counter_updown_param.md
COUNTER_UPDOWN_PARAM -- requirements
Module: counter_updown_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: count register width in bits, legal range 2..64.
REQ-002 SHALL have parameter MAX_COUNT, default 2**WIDTH-1: terminal value; legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 SHALL have parameter PRESCALE, default 1: number of enabled cycles per count step; legal range 1..65535.
REQ-005 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port n_reset  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port clear  in  1: synchronous clear of the count to 0.
REQ-008 SHALL have port load  in  1: synchronous load of load_value.
REQ-009 SHALL have port load_value  in  WIDTH: value to load.
REQ-010 SHALL have port enable  in  1: count enable.
REQ-011 SHALL have port up_down  in  1: direction; 1 = up, 0 = down.
REQ-012 SHALL have port Q  out  WIDTH: registered count.
REQ-013 SHALL have port at_limit  out  1: combinational; (up_down & Q==MAX_COUNT) | (~up_down & Q==0).
REQ-014 SHALL have port carry_out  out  1: combinational; enable & step_tick & at_limit; used as the enable of the next cascaded stage.
REQ-015 SHALL have port wrap  out  1: registered one-cycle pulse, high in the cycle after a wrap step.

Function
REQ-016 Priority SHALL be clear > load > count; when clear or load is asserted, the count step is suppressed.
REQ-017 The load SHALL write min(load_value, MAX_COUNT) to Q.
REQ-018 An internal prescale counter SHALL advance only when enable=1 and clear=0 and load=0.
REQ-019 step_tick SHALL be asserted when the prescale counter equals PRESCALE-1; the prescale counter then returns to 0.
REQ-020 With PRESCALE=1, step_tick SHALL be constantly 1.
REQ-021 The prescale counter SHALL be zeroed by clear, by load and by reset; it SHALL hold its value when enable=0.
REQ-022 A count step (enable & step_tick) SHALL change Q to Q+1 when counting up and Q-1 when counting down.
REQ-023 Up at MAX_COUNT: if SATURATE=0, Q SHALL go to 0 and wrap SHALL pulse next cycle; if SATURATE=1, Q SHALL hold and wrap SHALL stay 0.
REQ-024 Down at 0: if SATURATE=0, Q SHALL go to MAX_COUNT and wrap SHALL pulse; if SATURATE=1, Q SHALL hold.
REQ-025 Q SHALL never exceed MAX_COUNT; intermediate arithmetic SHALL be WIDTH+1 bits with no truncation error at 2**WIDTH-1.
REQ-026 A change of up_down SHALL take effect on the same cycle's step; at_limit SHALL follow up_down combinationally.
REQ-027 wrap SHALL be 0 in every cycle not directly following a wrap step, including after clear and load.
REQ-028 The latency from a qualifying edge to the new Q SHALL be one clock.

Reset
REQ-029 n_reset=0 SHALL immediately force Q=0, wrap=0 and prescale counter=0, independent of clk.
REQ-030 Reset deassertion SHALL be safe: the first count step SHALL occur on the first enabled edge after release, per the prescale rules.
REQ-031 Reset asserted mid-prescale or mid-wrap SHALL discard all partial state; no wrap pulse SHALL escape after reset.

Structure
REQ-032 Package counter_pkg SHALL hold the direction constants DIR_UP=1 and DIR_DOWN=0, and the mode constants MODE_WRAP=0 and MODE_SAT=1.
REQ-033 The prescaler SHALL be the single sub-module counter_prescaler (parameter PRESCALE; ports clk, n_reset, clr, enable, tick).
REQ-034 The block SHALL cascade via carry_out -> enable so that two WIDTH instances form one 2*WIDTH counter.

Verification
REQ-035 WIDTH=8, MAX_COUNT=9, wrap mode, up, enable held: Q SHALL read 0..9,0; wrap SHALL be high exactly 1 cycle after 9->0; carry_out SHALL be high while Q=9.
REQ-036 Same config, down from Q=0: Q SHALL be 9 next cycle and wrap SHALL pulse; in SATURATE=1, Q SHALL stay 0 and wrap SHALL stay 0.
REQ-037 PRESCALE=3: Q SHALL step every 3rd enabled cycle; enable dropped for 2 cycles mid-prescale SHALL delay the step by exactly 2 cycles.
REQ-038 With clear=1, load=1, load_value=5 and enable=1 in the same cycle: Q SHALL be 0; with load alone and load_value=200 (MAX_COUNT=9): Q SHALL be 9.
REQ-039 n_reset pulsed low between clock edges with Q=7 and the prescaler mid-count: Q SHALL be 0 immediately; the next step SHALL come PRESCALE enabled cycles after release.
REQ-040 Two WIDTH=16 instances cascaded, high stage loaded to 0x0000 and low stage to 0xFFFF, up: the combined value SHALL become 0x00010000 after one step.
